// File: rtl/branch_comp_pipe_if.sv
// Handshake bundle for branch_comp_pipe: operand/request side and result side.
interface branch_comp_pipe_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [2:0]      in_funct3;
    logic            in_mode;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_taken;
    logic            out_illegal;

    // The compare unit itself.
    modport slave (
        input  in_valid, in_a, in_b, in_funct3, in_mode, out_ready,
        output in_ready, out_valid, out_result, out_taken, out_illegal
    );

    // Whoever feeds operands and consumes results.
    modport master (
        output in_valid, in_a, in_b, in_funct3, in_mode, out_ready,
        input  in_ready, out_valid, out_result, out_taken, out_illegal
    );
endinterface

// File: rtl/branch_comp_pipe.sv
// Two-stage elastic branch / set-less-than compare unit with flush and a
// saturating counter of delivered taken branches.
module branch_comp_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    branch_comp_pipe_if.slave bus,
    output logic [CNT_W-1:0] taken_count
);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic            r_s1_valid;
    logic            r_s1_eq;
    logic            r_s1_lt_u;
    logic            r_s1_lt_s;
    logic [2:0]      r_s1_funct3;
    logic            r_s1_mode;
    logic            r_s2_valid;
    logic [XLEN-1:0] r_out_result;
    logic            r_out_taken;
    logic            r_out_illegal;
    logic [CNT_W-1:0] r_taken_count;

    logic [XLEN:0]   w_diff;
    logic            w_eq;
    logic            w_lt_u;
    logic            w_lt_s;
    logic            w_s1_adv;
    logic            w_s2_adv;
    logic            w_flag;
    logic            w_illegal;
    logic            w_taken;

    // Operand comparison from a single widened subtraction; the extra top bit is the borrow.
    always_comb begin
        w_diff = {1'b0, bus.in_a} - {1'b0, bus.in_b};
        w_eq   = (w_diff[XLEN-1:0] == '0);
        w_lt_u = w_diff[XLEN];
        // Differing signs decide directly; equal signs cannot overflow so the diff sign holds.
        w_lt_s = (bus.in_a[XLEN-1] != bus.in_b[XLEN-1]) ? bus.in_a[XLEN-1] : w_diff[XLEN-1];
    end

    // Pipeline advance: a stage moves when it is empty or its successor moves.
    always_comb begin
        w_s2_adv     = ~r_s2_valid | bus.out_ready;
        w_s1_adv     = ~r_s1_valid | w_s2_adv;
        bus.in_ready = w_s1_adv;
    end

    // Condition select from the stage-1 flags; unsupported combinations yield a zero flag.
    always_comb begin
        w_flag    = 1'b0;
        w_illegal = 1'b0;
        if (!r_s1_mode) begin
            unique case (r_s1_funct3)
                3'b000:         w_flag = r_s1_eq;
                3'b001:         w_flag = ~r_s1_eq;
                3'b100:         w_flag = r_s1_lt_s;
                3'b101:         w_flag = ~r_s1_lt_s;
                3'b110:         w_flag = r_s1_lt_u;
                3'b111:         w_flag = ~r_s1_lt_u;
                3'b010, 3'b011: w_illegal = 1'b1;
            endcase
        end else begin
            case (r_s1_funct3)
                3'b010:  w_flag = r_s1_lt_s;
                3'b011:  w_flag = r_s1_lt_u;
                default: w_illegal = 1'b1;
            endcase
        end
        w_taken = ~r_s1_mode & w_flag;
    end

    // Stage 1: capture compare flags and decode fields on accept; flush drops the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_eq     <= 1'b0;
            r_s1_lt_u   <= 1'b0;
            r_s1_lt_s   <= 1'b0;
            r_s1_funct3 <= 3'b000;
            r_s1_mode   <= 1'b0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_adv) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_s1_adv && bus.in_valid) begin
                r_s1_eq     <= w_eq;
                r_s1_lt_u   <= w_lt_u;
                r_s1_lt_s   <= w_lt_s;
                r_s1_funct3 <= bus.in_funct3;
                r_s1_mode   <= bus.in_mode;
            end
        end
    end

    // Stage 2: registered result; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid    <= 1'b0;
            r_out_result  <= '0;
            r_out_taken   <= 1'b0;
            r_out_illegal <= 1'b0;
        end else begin
            if (flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_adv && r_s1_valid) begin
                r_out_result  <= {{(XLEN-1){1'b0}}, w_flag};
                r_out_taken   <= w_taken;
                r_out_illegal <= w_illegal;
            end
        end
    end

    // Count taken branches actually handed over, including one delivered during a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_count <= '0;
        end else if (r_s2_valid && bus.out_ready && r_out_taken && (r_taken_count != CntMax)) begin
            r_taken_count <= r_taken_count + CntOne;
        end
    end

    assign bus.out_valid   = r_s2_valid;
    assign bus.out_result  = r_out_result;
    assign bus.out_taken   = r_out_taken;
    assign bus.out_illegal = r_out_illegal;
    assign taken_count     = r_taken_count;
endmodule
